// File: rtl/seq_pkg.sv
// Shared state encodings and default widths for the serial pattern generator.
// Also used by the detector bench so both sides agree on pattern geometry.
package seq_pkg;

    localparam int PAT_W_D = 4;
    localparam int CNT_W_D = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/seq_gen_moore_if.sv
// Start handshake and serial output bundle for seq_gen_moore.
// master = pattern source / observer, slave = generator.
interface seq_gen_moore_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
);

    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic             ready;
    logic             out;
    logic             out_valid;
    logic             done;

    modport master (
        output start, pattern, repeat_n,
        input  ready, out, out_valid, done
    );

    modport slave (
        input  start, pattern, repeat_n,
        output ready, out, out_valid, done
    );

endinterface

// File: rtl/seq_piso.sv
// Parallel-load, left-shift register; load has priority over shift.
// msb is the bit currently presented on the serial line.
module seq_piso #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/seq_gen_moore.sv
// Moore serial pattern transmitter: MSB-first, repeated repeat_n times.
// Define SEQ_GEN_GAP_EN for a one-cycle idle gap between repetitions.
module seq_gen_moore
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_D,
    parameter int CNT_W = CNT_W_D
) (
    input  logic            clk,
    input  logic            reset,
    seq_gen_moore_if.slave  bus
);

    localparam int BW = $clog2(PAT_W);

    state_t           state;
    state_t           nxt;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] load_d;
    logic [BW-1:0]    bit_q;
    logic [CNT_W-1:0] rep_q;
    logic             load;
    logic             shift;
    logic             accept;
    logic             rep_dec;
    logic             last;
    logic             msb;

    assign last = (bit_q == BW'(PAT_W - 1));

    always_comb begin
        nxt     = state;
        load    = 1'b0;
        shift   = 1'b0;
        accept  = 1'b0;
        rep_dec = 1'b0;
        load_d  = pat_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    load   = 1'b1;
                    load_d = bus.pattern;
                    nxt    = (bus.repeat_n == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (last) begin
                    if (rep_q > CNT_W'(1)) begin
                        rep_dec = 1'b1;
`ifdef SEQ_GEN_GAP_EN
                        nxt     = GAP;
`else
                        load    = 1'b1;
`endif
                    end else begin
                        nxt = DONE;
                    end
                end
            end
`ifdef SEQ_GEN_GAP_EN
            GAP: begin
                load = 1'b1;
                nxt  = SHIFT;
            end
`endif
            DONE: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pat_q <= '0;
            bit_q <= '0;
            rep_q <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                pat_q <= bus.pattern;
                rep_q <= bus.repeat_n;
                bit_q <= '0;
            end else if (rep_dec) begin
                rep_q <= rep_q - CNT_W'(1);
                bit_q <= '0;
            end else if (shift) begin
                bit_q <= bit_q + BW'(1);
            end
        end
    end

    seq_piso #(
        .W (PAT_W)
    ) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .d     (load_d),
        .msb   (msb)
    );

    // Outputs decode registered state only.
    assign bus.ready     = (state == IDLE);
    assign bus.out_valid = (state == SHIFT);
    assign bus.out       = (state == SHIFT) & msb;
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_seq_gen_moore.sv
// Scoreboard bench for seq_gen_moore: stimulus pushes expected tokens,
// a negedge monitor pops and checks every valid bit and done pulse.
module tb_seq_gen_moore;

`ifdef SEQ_GEN_GAP_EN
    localparam int GAPC = 1;
`else
    localparam int GAPC = 0;
`endif

    typedef struct {
        int cyc;
        bit is_done;
        bit val;
    } tok_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    tok_t sbq[$];
    tok_t mt;

    seq_gen_moore_if #(.PAT_W(4), .CNT_W(4)) bus ();

    seq_gen_moore #(
        .PAT_W (4),
        .CNT_W (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus.out_valid || bus.done) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected: valid=%0b done=%0b cyc %0d",
                             bus.out_valid, bus.done, cyc);
                end else begin
                    mt = sbq.pop_front();
                    if (mt.cyc != cyc || mt.is_done != bus.done ||
                        mt.is_done == bus.out_valid ||
                        (!mt.is_done && mt.val != bus.out)) begin
                        n_bad++;
                        $display("FAIL token: got cyc=%0d done=%0b out=%0b exp cyc=%0d done=%0b out=%0b",
                                 cyc, bus.done, bus.out,
                                 mt.cyc, mt.is_done, mt.val);
                    end
                end
            end
            if (!bus.out_valid)
                chk("out_idle", int'(bus.out), 0);
        end
    end

    task automatic chk_idle(input string nm);
        chk({nm, "_ready"}, int'(bus.ready), 1);
        chk({nm, "_valid"}, int'(bus.out_valid), 0);
        chk({nm, "_out"}, int'(bus.out), 0);
        chk({nm, "_done"}, int'(bus.done), 0);
    endtask

    task automatic push(input int c, input bit dn, input bit v);
        tok_t t;
        t.cyc = c;
        t.is_done = dn;
        t.val = v;
        sbq.push_back(t);
    endtask

    task automatic run(input logic [3:0] p, input int r, input bit hold);
        int e0;
        int d;
        @(negedge clk);
        bus.start = 1'b1;
        bus.pattern = p;
        bus.repeat_n = 4'(r);
        e0 = cyc;
        for (int rr = 0; rr < r; rr++)
            for (int i = 0; i < 4; i++)
                push(e0 + 1 + rr * (4 + GAPC) + i, 1'b0, p[3-i]);
        d = (r == 0) ? 1 : r * 4 + (r - 1) * GAPC + 1;
        push(e0 + d, 1'b1, 1'b0);
        for (int k = 1; k <= d + 1; k++) begin
            @(negedge clk);
            if (!hold || k >= d) bus.start = 1'b0;
            bus.pattern = ~p;
            bus.repeat_n = 4'(k);
            chk("ready", int'(bus.ready), (k == d + 1) ? 1 : 0);
        end
        chk("sb_empty", sbq.size(), 0);
    endtask

    initial begin
        int e0;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.pattern = '0;
        bus.repeat_n = '0;
        #1;
        chk_idle("in_reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_idle("post_reset");
        end

        run(4'b1011, 1, 1'b0);
        run(4'b0110, 3, 1'b1);
        run(4'b1111, 0, 1'b0);

        // Reset asserted in cycle 3 of a 1001 x2 run.
        @(negedge clk);
        bus.start = 1'b1;
        bus.pattern = 4'b1001;
        bus.repeat_n = 4'd2;
        e0 = cyc;
        push(e0 + 1, 1'b0, 1'b1);
        push(e0 + 2, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk_idle("abort");
        @(negedge clk);
        chk_idle("abort_hold");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle("after_abort");
        end
        chk("abort_sb", sbq.size(), 0);

        run(4'b1001, 2, 1'b0);
        run(4'b1100, 15, 1'b0);
        run(4'b0101, 1, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
